// File: rtl/coolgirl_irq_pkg.sv
// Shared constants for the MMC3-family scanline IRQ logic.
// Register selects are {A14, A13, A0} of the CPU address.
package coolgirl_irq_pkg;

  localparam logic [2:0] IRQ_LATCH   = 3'b100;
  localparam logic [2:0] IRQ_RELOAD  = 3'b101;
  localparam logic [2:0] IRQ_DISABLE = 3'b110;
  localparam logic [2:0] IRQ_ENABLE  = 3'b111;

  function automatic int low_cnt_w(input int low_min);
    return (low_min < 1) ? 1 : $clog2(low_min + 1);
  endfunction

endpackage

// File: rtl/a12_filter.sv
// PPU A12 rise qualifier: synchronise to M2, demand a run of
// low samples, then flag one scanline clock per qualified rise.
module a12_filter
  import coolgirl_irq_pkg::*;
#(
  parameter int A12_LOW_MIN = 3
) (
  input  logic m2,
  input  logic rst_n,
  input  logic ppu_a12,
  output logic clk_ev
);

  localparam int W = low_cnt_w(A12_LOW_MIN);
  localparam logic [W-1:0] LOW_MAX = W'(A12_LOW_MIN);

  logic         sync1_q;
  logic         sync2_q;
  logic [W-1:0] low_cnt_q;
  logic [W-1:0] low_cnt_d;

  always_comb begin
    low_cnt_d = low_cnt_q;
    if (sync2_q)
      low_cnt_d = '0;
    else if (low_cnt_q != LOW_MAX)
      low_cnt_d = low_cnt_q + W'(1);
  end

  // Fires on the fall that first sees A12 high after a long low run.
  assign clk_ev = sync2_q && (low_cnt_q == LOW_MAX);

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      low_cnt_q <= '0;
    end else begin
      sync1_q   <= ppu_a12;
      sync2_q   <= sync1_q;
      low_cnt_q <= low_cnt_d;
    end
  end

endmodule

// File: rtl/mmc3_irq_unit.sv
// MMC3 scanline IRQ: $C000-$FFFF decode, reload/down counter
// and the pending flag that drives the cartridge /IRQ line.
module mmc3_irq_unit
  import coolgirl_irq_pkg::*;
#(
  parameter int A12_LOW_MIN = 3,
  parameter bit REV_A       = 1'b0
) (
  input  logic        m2,
  input  logic        rst_n,
  input  logic        mapper_sel,
  input  logic        romsel,
  input  logic        cpu_rw_in,
  input  logic [14:0] cpu_addr_in,
  input  logic [7:0]  cpu_data_in,
  input  logic        ppu_a12,
  output logic        irq,
  output logic [7:0]  irq_counter
);

  logic       clk_ev;
  logic       wr;
  logic [2:0] reg_sel;
  logic       reg_wr;
  logic [7:0] next_cnt;
  logic       set_ok;
  logic       unused_addr;

  logic [7:0] latch_q, latch_d;
  logic [7:0] counter_q, counter_d;
  logic       reload_q, reload_d;
  logic       irq_en_q, irq_en_d;
  logic       pending_q, pending_d;

  a12_filter #(
    .A12_LOW_MIN(A12_LOW_MIN)
  ) u_a12_filter (
    .m2     (m2),
    .rst_n  (rst_n),
    .ppu_a12(ppu_a12),
    .clk_ev (clk_ev)
  );

  assign wr          = mapper_sel & ~romsel & ~cpu_rw_in;
  assign reg_sel     = {cpu_addr_in[14], cpu_addr_in[13], cpu_addr_in[0]};
  assign reg_wr      = wr & reg_sel[2];
  assign unused_addr = ^cpu_addr_in[12:1];

  assign next_cnt = (counter_q == 8'd0 || reload_q) ? latch_q
                                                    : counter_q - 8'd1;
  // Rev A stays quiet when a zero counter merely reloads zero.
  assign set_ok   = REV_A ? (counter_q != 8'd0 || reload_q) : 1'b1;

  always_comb begin
    latch_d   = latch_q;
    counter_d = counter_q;
    reload_d  = reload_q;
    irq_en_d  = irq_en_q;
    pending_d = pending_q;
    if (reg_wr) begin
      unique case (reg_sel)
        IRQ_LATCH:   latch_d = cpu_data_in;
        IRQ_RELOAD: begin
          counter_d = 8'd0;
          reload_d  = 1'b1;
        end
        IRQ_DISABLE: begin
          irq_en_d  = 1'b0;
          pending_d = 1'b0;
        end
        IRQ_ENABLE:  irq_en_d = 1'b1;
        default: ;
      endcase
    end else if (clk_ev) begin
      counter_d = next_cnt;
      reload_d  = 1'b0;
      if (next_cnt == 8'd0 && irq_en_q && set_ok)
        pending_d = 1'b1;
    end
  end

  always_ff @(negedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      latch_q   <= 8'd0;
      counter_q <= 8'd0;
      reload_q  <= 1'b0;
      irq_en_q  <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      latch_q   <= latch_d;
      counter_q <= counter_d;
      reload_q  <= reload_d;
      irq_en_q  <= irq_en_d;
      pending_q <= pending_d;
    end
  end

  assign irq         = ~(pending_q & mapper_sel);
  assign irq_counter = counter_q;

endmodule

// File: tb/tb_mmc3_irq_unit.sv
// Directed bench for mmc3_irq_unit: a vector table for the main
// count/ack/latch-0 flow plus hand sequences for filter/collision/reset.
module tb_mmc3_irq_unit;

  logic        m2;
  logic        rst_n;
  logic        mapper_sel;
  logic        romsel;
  logic        cpu_rw_in;
  logic [14:0] cpu_addr_in;
  logic [7:0]  cpu_data_in;
  logic        ppu_a12;
  logic        irq, irq_a;
  logic [7:0]  cnt, cnt_a;

  int passed = 0;
  int total  = 0;

  mmc3_irq_unit #(.A12_LOW_MIN(3), .REV_A(1'b0)) dut (
    .m2(m2), .rst_n(rst_n), .mapper_sel(mapper_sel), .romsel(romsel),
    .cpu_rw_in(cpu_rw_in), .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12),
    .irq(irq), .irq_counter(cnt)
  );

  mmc3_irq_unit #(.A12_LOW_MIN(3), .REV_A(1'b1)) dut_a (
    .m2(m2), .rst_n(rst_n), .mapper_sel(mapper_sel), .romsel(romsel),
    .cpu_rw_in(cpu_rw_in), .cpu_addr_in(cpu_addr_in),
    .cpu_data_in(cpu_data_in), .ppu_a12(ppu_a12),
    .irq(irq_a), .irq_counter(cnt_a)
  );

  initial m2 = 1'b1;
  always #5 m2 = ~m2;

  typedef enum logic [1:0] {OP_WR, OP_RISE, OP_SEL} op_e;

  typedef struct {
    op_e         op;
    logic [14:0] addr;
    logic [7:0]  data;
    logic        exp_irq;
    logic        exp_irq_a;
    logic [7:0]  exp_cnt;
    string       name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(op_e op, logic [14:0] a, logic [7:0] d,
                              logic ei, logic eia, logic [7:0] ec,
                              string n);
    vec_t v;
    v.op = op; v.addr = a; v.data = d;
    v.exp_irq = ei; v.exp_irq_a = eia; v.exp_cnt = ec; v.name = n;
    return v;
  endfunction

  task automatic chk(string n, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", n, act, exp);
  endtask

  task automatic step();
    @(negedge m2);
    #1;
  endtask

  task automatic cpu_write(logic [14:0] a, logic [7:0] d);
    romsel = 1'b0; cpu_rw_in = 1'b0; cpu_addr_in = a; cpu_data_in = d;
    step();
    romsel = 1'b1; cpu_rw_in = 1'b1;
  endtask

  task automatic a12_rise();
    ppu_a12 = 1'b0;
    repeat (4) step();
    ppu_a12 = 1'b1;
    repeat (3) step();
  endtask

  task automatic chk_both(string n, logic ei, logic eia, logic [7:0] ec);
    chk({n, "_irq"}, {7'd0, irq}, {7'd0, ei});
    chk({n, "_irqA"}, {7'd0, irq_a}, {7'd0, eia});
    chk({n, "_cnt"}, cnt, ec);
    chk({n, "_cntA"}, cnt_a, ec);
  endtask

  initial begin
    rst_n = 1'b0; mapper_sel = 1'b1; romsel = 1'b1; cpu_rw_in = 1'b1;
    cpu_addr_in = '0; cpu_data_in = '0; ppu_a12 = 1'b0;

    vecs.push_back(mk(OP_WR,   15'h4000, 8'h03, 1, 1, 8'd0, "lat3"));
    vecs.push_back(mk(OP_WR,   15'h4001, 8'h00, 1, 1, 8'd0, "rld"));
    vecs.push_back(mk(OP_WR,   15'h6001, 8'h00, 1, 1, 8'd0, "en"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 1, 1, 8'd3, "r1"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 1, 1, 8'd2, "r2"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 1, 1, 8'd1, "r3"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 0, 0, 8'd0, "r4zero"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 0, 0, 8'd3, "r5reload"));
    vecs.push_back(mk(OP_WR,   15'h6000, 8'h00, 1, 1, 8'd3, "ack"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 1, 1, 8'd2, "d2"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 1, 1, 8'd1, "d1"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 1, 1, 8'd0, "d0noirq"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 1, 1, 8'd3, "d3"));
    vecs.push_back(mk(OP_WR,   15'h0000, 8'h55, 1, 1, 8'd3, "nonblk"));
    vecs.push_back(mk(OP_WR,   15'h6001, 8'h00, 1, 1, 8'd3, "reen"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 1, 1, 8'd2, "e2"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 1, 1, 8'd1, "e1"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 0, 0, 8'd0, "e0"));
    vecs.push_back(mk(OP_SEL,  15'h0,    8'h00, 1, 1, 8'd0, "desel"));
    vecs.push_back(mk(OP_WR,   15'h6000, 8'h00, 1, 1, 8'd0, "deselwr"));
    vecs.push_back(mk(OP_SEL,  15'h0,    8'h01, 0, 0, 8'd0, "resel"));
    vecs.push_back(mk(OP_WR,   15'h6000, 8'h00, 1, 1, 8'd0, "ack2"));
    vecs.push_back(mk(OP_WR,   15'h4000, 8'h00, 1, 1, 8'd0, "lat0"));
    vecs.push_back(mk(OP_WR,   15'h4001, 8'h00, 1, 1, 8'd0, "l0rld"));
    vecs.push_back(mk(OP_WR,   15'h6001, 8'h00, 1, 1, 8'd0, "l0en"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 0, 0, 8'd0, "l0first"));
    vecs.push_back(mk(OP_WR,   15'h6000, 8'h00, 1, 1, 8'd0, "l0ack"));
    vecs.push_back(mk(OP_WR,   15'h6001, 8'h00, 1, 1, 8'd0, "l0en2"));
    vecs.push_back(mk(OP_RISE, 15'h0,    8'h00, 0, 1, 8'd0, "l0again"));
    vecs.push_back(mk(OP_WR,   15'h6000, 8'h00, 1, 1, 8'd0, "l0ack2"));

    #3;
    chk_both("reset", 1'b1, 1'b1, 8'd0);
    #8;
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      unique case (vecs[i].op)
        OP_WR:   cpu_write(vecs[i].addr, vecs[i].data);
        OP_RISE: a12_rise();
        OP_SEL: begin
          mapper_sel = vecs[i].data[0];
          step();
        end
        default: ;
      endcase
      chk_both(vecs[i].name, vecs[i].exp_irq, vecs[i].exp_irq_a,
               vecs[i].exp_cnt);
    end

    // Filter: one low sample between rises yields a single event.
    cpu_write(15'h4000, 8'd5);
    cpu_write(15'h4001, 8'd0);
    a12_rise();
    chk("f_load", cnt, 8'd5);
    ppu_a12 = 1'b0;
    repeat (4) step();
    ppu_a12 = 1'b1; step();
    ppu_a12 = 1'b0; step();
    ppu_a12 = 1'b1; step();
    chk("f_ev", cnt, 8'd4);
    repeat (5) step();
    chk("f_once", cnt, 8'd4);
    ppu_a12 = 1'b0;
    repeat (4) step();
    ppu_a12 = 1'b1;
    step(); step();
    chk("lat_2falls", cnt, 8'd4);
    step();
    chk("lat_3falls", cnt, 8'd3);

    // Collision: $C001 on the same fall as a qualified rise.
    cpu_write(15'h6001, 8'd0);
    cpu_write(15'h4001, 8'd0);
    a12_rise();
    chk("c_pre", cnt, 8'd5);
    ppu_a12 = 1'b0;
    repeat (4) step();
    ppu_a12 = 1'b1;
    step(); step();
    cpu_write(15'h4001, 8'd0);
    chk("c_cnt", cnt, 8'd0);
    chk("c_irq", {7'd0, irq}, 8'd1);
    a12_rise();
    chk("c_load", cnt, 8'd5);
    chk("c_noirq", {7'd0, irq}, 8'd1);

    // Asynchronous reset while irq asserted and mid-count.
    cpu_write(15'h4000, 8'd2);
    cpu_write(15'h4001, 8'd0);
    a12_rise();
    a12_rise();
    a12_rise();
    chk_both("pre_rst0", 1'b0, 1'b0, 8'd0);
    a12_rise();
    chk_both("pre_rst2", 1'b0, 1'b0, 8'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk_both("async_rst", 1'b1, 1'b1, 8'd0);
    #2;
    rst_n = 1'b1;
    a12_rise();
    chk_both("post_rst", 1'b1, 1'b1, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
